// File: rtl/uart_autobaud.sv
// Automatic baud-rate detector: times a 0x55 sync frame on rx_i and derives the
// 11-bit divisor for the 16x oversampling baud generator.
module uart_autobaud #(
   parameter int CNT_W      = 20,
   parameter int TIMEOUT    = 131071,
   parameter int DVSR_RESET = 650
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rx_i,
   input  logic        start_i,
   output logic [10:0] dvsr_o,
   output logic        locked_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      MEASURE,
      CALC,
      WAIT_STOP,
      ERR
   } stateT;

   stateT            state_q;
   logic             rxMeta_q, rxSync_q, rxPrev_q;
   logic [CNT_W-1:0] icnt_q, acc_q, i1_q;
   logic [2:0]       k_q;
   logic [10:0]      dvsrNext_q, dvsr_q;
   logic             locked_q, done_q, err_q;

   logic             fe, re, timeout, tooFar, qBad;
   logic [CNT_W-1:0] intv;
   logic [CNT_W:0]   diffA, diffB, diffMag, accRnd, q;

   assign fe      = !rxSync_q &&  rxPrev_q;
   assign re      =  rxSync_q && !rxPrev_q;
   assign timeout = (icnt_q == CNT_W'(TIMEOUT));

   // Interval deviation uses a guard bit so the sign of I - I1 is explicit.
   always_comb begin
      intv    = icnt_q + CNT_W'(1);
      diffA   = {1'b0, intv} - {1'b0, i1_q};
      diffB   = {1'b0, i1_q} - {1'b0, intv};
      diffMag = diffA[CNT_W] ? diffB : diffA;
      tooFar  = diffMag > ({1'b0, i1_q} >> 2);
      accRnd  = {1'b0, acc_q} + (CNT_W+1)'(64);
      q       = accRnd >> 7;
      qBad    = (q < (CNT_W+1)'(2)) || (q > (CNT_W+1)'(2048));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         rxMeta_q   <= 1'b1;
         rxSync_q   <= 1'b1;
         rxPrev_q   <= 1'b1;
         icnt_q     <= '0;
         acc_q      <= '0;
         i1_q       <= '0;
         k_q        <= '0;
         dvsrNext_q <= 11'(DVSR_RESET);
         dvsr_q     <= 11'(DVSR_RESET);
         locked_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rxMeta_q <= rx_i;
         rxSync_q <= rxMeta_q;
         rxPrev_q <= rxSync_q;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) state_q <= ARMED;
            end
            ARMED: begin
               if (fe) begin
                  icnt_q  <= '0;
                  acc_q   <= '0;
                  k_q     <= 3'd1;
                  state_q <= MEASURE;
               end
            end
            MEASURE: begin
               icnt_q <= icnt_q + CNT_W'(1);
               // A timeout wins over an edge arriving in the same cycle.
               if (timeout) begin
                  err_q   <= 1'b1;
                  state_q <= ERR;
               end else if (fe) begin
                  icnt_q <= '0;
                  acc_q  <= acc_q + intv;
                  k_q    <= k_q + 3'd1;
                  if (k_q == 3'd1) begin
                     i1_q <= intv;
                  end else if (tooFar) begin
                     err_q   <= 1'b1;
                     state_q <= ERR;
                  end else if (k_q == 3'd4) begin
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               if (qBad) begin
                  err_q   <= 1'b1;
                  state_q <= ERR;
               end else begin
                  dvsrNext_q <= q[10:0] - 11'd1;
                  icnt_q     <= '0;
                  state_q    <= WAIT_STOP;
               end
            end
            WAIT_STOP: begin
               icnt_q <= icnt_q + CNT_W'(1);
               if (timeout) begin
                  err_q   <= 1'b1;
                  state_q <= ERR;
               end else if (re) begin
                  dvsr_q   <= dvsrNext_q;
                  locked_q <= 1'b1;
                  done_q   <= 1'b1;
                  state_q  <= IDLE;
               end
            end
            ERR: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign dvsr_o   = dvsr_q;
   assign locked_o = locked_q;
   assign busy_o   = (state_q != IDLE);
   assign done_o   = done_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: sync frames at several bit widths, corrupted
// frames, divisor bounds, line-stuck timeout and reset in the middle of a frame.
module tb_uart_autobaud;

   localparam int TO = 6000;

   logic        clock = 1'b0;
   logic        reset;
   logic        rxI;
   logic        startI;
   logic [10:0] dvsrO;
   logic        lockedO, busyO, doneO, errO;

   int checks    = 0;
   int failures  = 0;
   int doneCount = 0;
   int errCount  = 0;

   always #5 clock = ~clock;

   uart_autobaud #(.TIMEOUT(TO)) dut (
      .clk_i   (clock),
      .rst_i   (reset),
      .rx_i    (rxI),
      .start_i (startI),
      .dvsr_o  (dvsrO),
      .locked_o(lockedO),
      .busy_o  (busyO),
      .done_o  (doneO),
      .err_o   (errO)
   );

   // Pulse counters sampled on the falling edge, away from the active edge.
   always @(negedge clock) begin
      if (doneO === 1'b1) doneCount++;
      if (errO === 1'b1) errCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic armDetector();
      @(posedge clock); #1 startI = 1'b1;
      @(posedge clock); #1 startI = 1'b0;
      doneCount = 0;
      errCount  = 0;
   endtask

   // Sends start bit, 8 data bits LSB first and a stop bit; optional start pulse mid-frame.
   task automatic applyStimulus(input logic [7:0] data, input int bitClks, input int pulseAtBit);
      logic [9:0] frame;
      frame = {1'b1, data, 1'b0};
      for (int b = 0; b < 10; b++) begin
         rxI = frame[b];
         for (int c = 0; c < bitClks; c++) begin
            @(posedge clock); #1;
            startI = (b == pulseAtBit && c == bitClks / 2) ? 1'b1 : 1'b0;
         end
      end
      startI = 1'b0;
      repeat (20) @(posedge clock);
      #1;
   endtask

   initial begin
      int cnt;
      bit seen;
      reset  = 1'b1;
      rxI    = 1'b1;
      startI = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checkOutput("rst_dvsr",   dvsrO,   650);
      checkOutput("rst_locked", lockedO, 0);
      checkOutput("rst_busy",   busyO,   0);
      checkOutput("rst_done",   doneO,   0);
      checkOutput("rst_err",    errO,    0);

      // 868 clocks/bit: acc 6944, q 54, divisor 53.
      armDetector();
      checkOutput("arm_busy", busyO, 1);
      applyStimulus(8'h55, 868, -1);
      checkOutput("b868_done",   doneCount, 1);
      checkOutput("b868_err",    errCount,  0);
      checkOutput("b868_dvsr",   dvsrO,     53);
      checkOutput("b868_locked", lockedO,   1);
      checkOutput("b868_busy",   busyO,     0);

      // 1302 clocks/bit: acc 10416, q 81, divisor 80.
      armDetector();
      applyStimulus(8'h55, 1302, -1);
      checkOutput("b1302_done", doneCount, 1);
      checkOutput("b1302_dvsr", dvsrO,     80);

      armDetector();
      applyStimulus(8'h55, 868, -1);
      checkOutput("rearm_done", doneCount, 1);
      checkOutput("rearm_dvsr", dvsrO,     53);

      // 0x57: first interval 4 bits, second 2 bits -> deviation abort.
      armDetector();
      applyStimulus(8'h57, 400, -1);
      checkOutput("bad_err",    errCount,  1);
      checkOutput("bad_done",   doneCount, 0);
      checkOutput("bad_dvsr",   dvsrO,     53);
      checkOutput("bad_locked", lockedO,   1);
      checkOutput("bad_busy",   busyO,     0);

      // 23 clocks/bit: acc 184, q 1 -> below the minimum quotient.
      armDetector();
      applyStimulus(8'h55, 23, -1);
      checkOutput("qlow_err",  errCount,  1);
      checkOutput("qlow_done", doneCount, 0);
      checkOutput("qlow_dvsr", dvsrO,     53);

      // 24 clocks/bit: acc 192, q 2 -> smallest accepted quotient, divisor 1.
      armDetector();
      applyStimulus(8'h55, 24, -1);
      checkOutput("qmin_done", doneCount, 1);
      checkOutput("qmin_err",  errCount,  0);
      checkOutput("qmin_dvsr", dvsrO,     1);

      // 434 clocks/bit with a start pulse during MEASURE: acc 3472, q 27, divisor 26.
      armDetector();
      applyStimulus(8'h55, 434, 3);
      checkOutput("ign_done", doneCount, 1);
      checkOutput("ign_err",  errCount,  0);
      checkOutput("ign_dvsr", dvsrO,     26);

      // Line stuck low: err appears TO cycles after the icnt clear plus 4 cycles of latency.
      armDetector();
      @(posedge clock); #1 rxI = 1'b0;
      cnt  = 0;
      seen = 1'b0;
      for (int i = 0; i < TO + 50; i++) begin
         @(posedge clock);
         cnt++;
         @(negedge clock);
         if (errO === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("stuck_seen",  seen, 1);
      checkOutput("stuck_delay", cnt,  TO + 4);
      @(posedge clock); #1;
      checkOutput("stuck_busy", busyO, 0);
      checkOutput("stuck_dvsr", dvsrO, 26);
      rxI = 1'b1;
      repeat (10) @(posedge clock);

      // Reset in the middle of a frame, then a clean lock.
      armDetector();
      #1 rxI = 1'b0;
      repeat (868) @(posedge clock);
      #1 rxI = 1'b1;
      repeat (868) @(posedge clock);
      #1 rxI = 1'b0;
      repeat (400) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      checkOutput("mid_dvsr",   dvsrO,   650);
      checkOutput("mid_locked", lockedO, 0);
      checkOutput("mid_busy",   busyO,   0);
      checkOutput("mid_done",   doneO,   0);
      checkOutput("mid_err",    errO,    0);
      rxI = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      repeat (5) @(posedge clock);
      armDetector();
      applyStimulus(8'h55, 868, -1);
      checkOutput("relock_done",   doneCount, 1);
      checkOutput("relock_dvsr",   dvsrO,     53);
      checkOutput("relock_locked", lockedO,   1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
